cgra_conf_seq: RTL and testbench
================================

Name: cgra_conf_seq

Overview:
- Parametrised configuration loader and sequencer for the CGRA. Next generation of the fixed 512-bit / 352-bit conf path.
- Fetches a header word, then NUM_CONF configuration words, from the shared read stream into a local conf memory.
- Replays the conf memory to the execution unit with a stallable PC that loops back to start_loop.
- Adds what the fixed version lacks: parametrised widths/depth, header sanity checks, load progress and error reporting, clean abort.

Parameters:
DATA_W, 512, read-stream word width (header and conf words arrive one per beat)
CONF_W, 352, configuration width; taken from rd_data[CONF_W-1:0]; CONF_W <= DATA_W
CONF_DEPTH, 64, conf memory entries; power of two
PC_W, 6, log2(CONF_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
start  in  1  begin load+run; sampled only in IDLE
abort  in  1  synchronous abort to IDLE, any state
available_read  in  1  read stream has a word
rd_data  in  DATA_W  read stream word
req_rd_data  out  1  consume rd_data this cycle
stall  in  1  freeze PC (driven by unit's stop_exec)
exec_done  in  1  unit finished; return to IDLE
initial_conf  out  DATA_W  registered header word
conf_out  out  CONF_W  registered current configuration
pc  out  PC_W  current conf index
start_unit_exec  out  1  high for whole RUN state
load_busy  out  1  high in HDR or LOAD
hdr_err  out  1  sticky header error, cleared on next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE; pc=0; conf_out=0; initial_conf=0; all flags 0; load counter 0. Memory contents are not reset.
- Beat rule: a word is consumed exactly when req_rd_data=1. req_rd_data = available_read && state in {HDR, LOAD}, combinational. rd_data is sampled on that same clock edge.
- Header fields: num_conf = initial_conf[31:0]; start_loop = initial_conf[63:32]. Other bits pass through untouched.
- States:
  - IDLE: start=1 -> HDR, clear hdr_err.
  - HDR: on beat, latch initial_conf, then compute eff_n and eff_loop:
    - num_conf == 0 -> hdr_err=1, go IDLE.
    - num_conf > CONF_DEPTH -> eff_n = CONF_DEPTH, hdr_err=1, continue.
    - start_loop >= eff_n -> eff_loop = 0, hdr_err=1, continue.
    - Otherwise -> LOAD with load counter=0.
  - LOAD: on each beat, mem[cnt] <= rd_data[CONF_W-1:0], cnt++.
    - On the beat writing entry eff_n-1 -> RUN. Beats beyond eff_n are never requested.
    - Entering RUN: pc=0; conf_out=mem[0], using a write-bypass if entry 0 was written this cycle.
  - RUN: start_unit_exec=1. Each cycle with stall=0:
    - pc <= (pc == eff_n-1) ? eff_loop : pc+1.
    - conf_out updates in the same cycle as pc, with 1-cycle registered memory read: conf_out always equals mem[pc].
    - stall=1 holds pc and conf_out.
    - exec_done=1 -> IDLE; pc and conf_out hold their last values.
- Priority: abort over exec_done over stall over start. abort in any state -> IDLE next cycle; req_rd_data drops the same cycle.
- start outside IDLE is ignored.
- eff_n = 1: pc stays 0 forever.
- available_read low mid-LOAD: wait indefinitely, no timeout.
- Counter widths: PC_W for pc; PC_W+1 for the load counter. Header compares are done at 32 bits.

Optional Feature:
- Macro LOOP_COUNT_EN.
- Defined: adds output loop_iter (32 bits).
  - Cleared on entry to RUN.
  - Increments when pc wraps to eff_loop, including eff_n=1 and non-stalled cycles.
  - Saturates at all-ones.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package cgra_conf_pkg:
  - state encoding IDLE/HDR/LOAD/RUN;
  - header field offsets and widths (NUM_CONF_LSB=0, START_LOOP_LSB=32, field width 32).
- One sub-module, cgra_conf_mem: simple dual-port RAM, CONF_DEPTH x CONF_W, one write port, registered read port.
- Write-bypass for the first-entry corner stays in the parent.

Test Plan:
1. Normal: header num_conf=4, start_loop=1, four conf words A,B,C,D, no stall -> RUN; conf_out sequence A,B,C,D,B,C,D,B...; hdr_err=0; exactly 5 req_rd_data beats.
2. Stall and backpressure:
   - available_read toggles every cycle during LOAD -> load completes after 5 accepted beats.
   - stall high 3 cycles at pc=2 -> pc and conf_out hold 3 cycles, then resume at 3.
3. Header errors:
   - num_conf=0 -> hdr_err=1, back to IDLE, no further requests.
   - num_conf=100 with CONF_DEPTH=64 -> exactly 64 conf beats, hdr_err=1, pc wraps 63->start_loop.
   - start_loop=7 with num_conf=4 -> wraps 3->0, hdr_err=1.
4. Abort mid-LOAD after 2 of 4 words -> IDLE next cycle, req_rd_data=0. A new start reloads cleanly and hdr_err clears.
5. Reset mid-RUN: rst low asynchronously -> all outputs 0 immediately; after release, state IDLE and start_unit_exec=0.
6. LOOP_COUNT_EN defined, num_conf=1 -> loop_iter increments every non-stalled RUN cycle. exec_done -> IDLE; loop_iter holds.

Source files
------------

// File: rtl/cgra_conf_pkg.sv
// Shared definitions for the CGRA configuration loader/sequencer:
// FSM state encoding and header field layout.
package cgra_conf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_LOAD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  localparam int HDR_FIELD_W    = 32;
  localparam int NUM_CONF_LSB   = 0;
  localparam int START_LOOP_LSB = 32;

endpackage

// File: rtl/cgra_conf_mem.sv
// Conf memory: CONF_DEPTH x CONF_W simple dual-port RAM, one write port and
// a registered read port whose output register is the only reset state.
module cgra_conf_mem #(
  parameter int CONF_W     = 352,
  parameter int CONF_DEPTH = 64,
  parameter int PC_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PC_W-1:0]   wr_addr,
  input  logic [CONF_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PC_W-1:0]   rd_addr,
  output logic [CONF_W-1:0] rd_data
);

  logic [CONF_W-1:0] r_mem [CONF_DEPTH];
  logic [CONF_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Read-before-write on a same-address collision; the parent bypasses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_q <= '0;
    else if (rd_en) r_q <= r_mem[rd_addr];
  end

  assign rd_data = r_q;

endmodule

// File: rtl/cgra_conf_seq.sv
// CGRA conf loader/sequencer: fetches a header plus NUM_CONF words, then replays
// them with a stallable looping PC. Optional LOOP_COUNT_EN adds loop_iter.
module cgra_conf_seq
  import cgra_conf_pkg::*;
#(
  parameter int DATA_W     = 512,
  parameter int CONF_W     = 352,
  parameter int CONF_DEPTH = 64,
  parameter int PC_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              available_read,
  input  logic [DATA_W-1:0] rd_data,
  output logic              req_rd_data,
  input  logic              stall,
  input  logic              exec_done,
  output logic [DATA_W-1:0] initial_conf,
  output logic [CONF_W-1:0] conf_out,
  output logic [PC_W-1:0]   pc,
  output logic              start_unit_exec,
  output logic              load_busy,
  output logic              hdr_err
`ifdef LOOP_COUNT_EN
  , output logic [31:0]     loop_iter
`endif
);

  state_e              r_state;
  logic [PC_W:0]       r_cnt;
  logic [PC_W:0]       r_eff_n;
  logic [PC_W-1:0]     r_eff_loop;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_init;
  logic                r_run;
  logic                r_busy;
  logic                r_err;
  logic                r_byp;
  logic [CONF_W-1:0]   r_byp_data;
`ifdef LOOP_COUNT_EN
  logic [31:0]         r_loop_iter;
`endif

  logic                w_beat;
  logic [31:0]         w_num;
  logic [31:0]         w_sl;
  logic                w_n_big;
  logic [PC_W:0]       w_hdr_n;
  logic                w_sl_bad;
  logic                w_last;
  logic                w_run_enter;
  logic                w_at_end;
  logic [PC_W-1:0]     w_pc_nxt;
  logic                w_run_step;
  logic                w_wr_en;
  logic                w_rd_en;
  logic [PC_W-1:0]     w_rd_addr;
  logic [CONF_W-1:0]   w_mem_q;

  // Abort drops the request in the same cycle it is raised.
  assign w_beat = available_read && !abort &&
                  ((r_state == ST_HDR) || (r_state == ST_LOAD));
  assign req_rd_data = w_beat;

  assign w_num    = rd_data[NUM_CONF_LSB +: HDR_FIELD_W];
  assign w_sl     = rd_data[START_LOOP_LSB +: HDR_FIELD_W];
  assign w_n_big  = w_num > 32'(CONF_DEPTH);
  assign w_hdr_n  = w_n_big ? (PC_W+1)'(CONF_DEPTH) : w_num[PC_W:0];
  assign w_sl_bad = w_sl >= 32'(w_hdr_n);

  assign w_last      = (r_cnt == r_eff_n - 1'b1);
  assign w_run_enter = (r_state == ST_LOAD) && w_beat && w_last;
  assign w_at_end    = ({1'b0, r_pc} == r_eff_n - 1'b1);
  assign w_pc_nxt    = w_at_end ? r_eff_loop : r_pc + 1'b1;
  assign w_run_step  = (r_state == ST_RUN) && !abort && !exec_done && !stall;

  // Memory is addressed with the next PC so its read register tracks pc.
  assign w_wr_en   = (r_state == ST_LOAD) && w_beat;
  assign w_rd_en   = w_run_enter || w_run_step;
  assign w_rd_addr = w_run_enter ? '0 : w_pc_nxt;

  cgra_conf_mem #(
    .CONF_W     (CONF_W),
    .CONF_DEPTH (CONF_DEPTH),
    .PC_W       (PC_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_addr (r_cnt[PC_W-1:0]),
    .wr_data (rd_data[CONF_W-1:0]),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (w_mem_q)
  );

  always_ff @(posedge clk) begin
    if (w_run_enter && (r_cnt == '0)) r_byp_data <= rd_data[CONF_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_eff_n    <= '0;
      r_eff_loop <= '0;
      r_pc       <= '0;
      r_init     <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_byp      <= 1'b0;
`ifdef LOOP_COUNT_EN
      r_loop_iter <= '0;
`endif
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_HDR;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        ST_HDR: begin
          if (w_beat) begin
            r_init <= rd_data;
            if (w_num == '0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_cnt      <= '0;
              r_eff_n    <= w_hdr_n;
              r_eff_loop <= w_sl_bad ? '0 : w_sl[PC_W-1:0];
              if (w_n_big || w_sl_bad) r_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
              r_run   <= 1'b1;
              r_pc    <= '0;
              // Single-entry program: entry 0 is being written right now.
              r_byp   <= (r_cnt == '0);
`ifdef LOOP_COUNT_EN
              r_loop_iter <= '0;
`endif
            end
          end
        end
        ST_RUN: begin
          if (exec_done) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
          end else if (!stall) begin
            r_pc  <= w_pc_nxt;
            r_byp <= 1'b0;
`ifdef LOOP_COUNT_EN
            if (w_at_end && (r_loop_iter != '1)) r_loop_iter <= r_loop_iter + 1'b1;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign conf_out        = r_byp ? r_byp_data : w_mem_q;
  assign initial_conf    = r_init;
  assign pc              = r_pc;
  assign start_unit_exec = r_run;
  assign load_busy       = r_busy;
  assign hdr_err         = r_err;
`ifdef LOOP_COUNT_EN
  assign loop_iter       = r_loop_iter;
`endif

endmodule

// File: tb/tb_cgra_conf_seq.sv
// Bench for cgra_conf_seq: header table plus randomized loads/stalls checked
// against a sequence model of the replayed program.
module tb_cgra_conf_seq;

  localparam int DATA_W     = 512;
  localparam int CONF_W     = 352;
  localparam int CONF_DEPTH = 64;
  localparam int PC_W       = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              available_read = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              req_rd_data;
  logic              stall = 1'b0;
  logic              exec_done = 1'b0;
  logic [DATA_W-1:0] initial_conf;
  logic [CONF_W-1:0] conf_out;
  logic [PC_W-1:0]   pc;
  logic              start_unit_exec;
  logic              load_busy;
  logic              hdr_err;
`ifdef LOOP_COUNT_EN
  logic [31:0]       loop_iter;
`endif

  always #5 clk = ~clk;

  cgra_conf_seq #(
    .DATA_W(DATA_W), .CONF_W(CONF_W), .CONF_DEPTH(CONF_DEPTH), .PC_W(PC_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .available_read  (available_read),
    .rd_data         (rd_data),
    .req_rd_data     (req_rd_data),
    .stall           (stall),
    .exec_done       (exec_done),
    .initial_conf    (initial_conf),
    .conf_out        (conf_out),
    .pc              (pc),
    .start_unit_exec (start_unit_exec),
    .load_busy       (load_busy),
    .hdr_err         (hdr_err)
`ifdef LOOP_COUNT_EN
    , .loop_iter     (loop_iter)
`endif
  );

  typedef struct {
    int num; int sl; int avail; int stall_pct; int run_n;
    bit err; int en; int el;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] words [0:CONF_DEPTH+1];
  int k, beats;
  int en, el, mpc;
  int unsigned wraps;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Header rules: clamp count to depth, fold an out-of-range loop start to 0.
  task automatic model_hdr(input int num, input int sl, output int e_n, output int e_l, output bit err);
    err = 0; e_n = 0; e_l = 0;
    if (num == 0) err = 1;
    else begin
      e_n = (num > CONF_DEPTH) ? CONF_DEPTH : num;
      if (num > CONF_DEPTH) err = 1;
      if (sl >= e_n) err = 1;
      else e_l = sl;
    end
  endtask

  task automatic begin_load(input int num, input int sl);
    words[0] = rnd_word();
    words[0][31:0]  = num;
    words[0][63:32] = sl;
    for (int i = 1; i <= CONF_DEPTH+1; i++) words[i] = rnd_word();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0; beats = 0;
  endtask

  // avail < 0 toggles available_read every cycle.
  task automatic feed(input int max_beats, input int avail);
    int cyc;
    bit r;
    cyc = 0;
    while (beats < max_beats && load_busy) begin
      if (cyc >= 3000) begin
        n_chk++; n_fail++;
        $display("FAIL load_timeout: beats %0d", beats);
        break;
      end
      available_read = (avail < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < avail);
      rd_data = (k <= CONF_DEPTH+1) ? words[k] : '0;
      #1 r = req_rd_data;
      @(negedge clk);
      if (r) begin beats++; k++; end
      cyc++;
    end
    available_read = 1'b0;
  endtask

  task automatic step(input bit st);
    stall = st;
    @(negedge clk);
    if (!st) begin
      if (mpc == en - 1) begin mpc = el; wraps++; end
      else mpc++;
    end
    chk("run_pc", DATA_W'(pc), DATA_W'(mpc));
    chk("run_conf", DATA_W'(conf_out), DATA_W'(words[mpc+1][CONF_W-1:0]));
    chk("run_flag", DATA_W'(start_unit_exec), DATA_W'(1));
`ifdef LOOP_COUNT_EN
    chk("loop_iter", DATA_W'(loop_iter), DATA_W'(wraps));
`endif
    stall = 1'b0;
  endtask

  task automatic enter_run(input int e_n, input int e_l);
    en = e_n; el = e_l; mpc = 0; wraps = 0;
    chk("enter_run", DATA_W'(start_unit_exec), DATA_W'(1));
    chk("enter_pc", DATA_W'(pc), '0);
    chk("enter_conf", DATA_W'(conf_out), DATA_W'(words[1][CONF_W-1:0]));
  endtask

  task automatic finish_run();
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    chk("done_run", DATA_W'(start_unit_exec), '0);
    chk("done_pc", DATA_W'(pc), DATA_W'(mpc));
    chk("done_conf", DATA_W'(conf_out), DATA_W'(words[mpc+1][CONF_W-1:0]));
`ifdef LOOP_COUNT_EN
    chk("done_iter", DATA_W'(loop_iter), DATA_W'(wraps));
`endif
    @(negedge clk);
    chk("idle_busy", DATA_W'(load_busy), '0);
  endtask

  task automatic run_vec(input vec_t v);
    begin_load(v.num, v.sl);
    feed(1000, v.avail);
    chk("beats", DATA_W'(beats), DATA_W'(v.en + 1));
    chk("hdr_err", DATA_W'(hdr_err), DATA_W'(v.err));
    chk("init_conf", initial_conf, words[0]);
    if (v.en == 0) begin
      available_read = 1'b1;
      #1 chk("zero_req", DATA_W'(req_rd_data), '0);
      @(negedge clk);
      chk("zero_req2", DATA_W'(req_rd_data), '0);
      chk("zero_run", DATA_W'(start_unit_exec), '0);
      available_read = 1'b0;
    end else begin
      enter_run(v.en, v.el);
      for (int i = 0; i < v.run_n; i++) step($urandom_range(99) < v.stall_pct);
      finish_run();
    end
  endtask

  vec_t tbl [8];

  initial begin
    vec_t rv;
    tbl[0] = '{4,   1,  100, 0,  10, 1'b0, 4,  1};
    tbl[1] = '{0,   0,  100, 0,  0,  1'b1, 0,  0};
    tbl[2] = '{100, 5,  100, 0,  70, 1'b1, 64, 5};
    tbl[3] = '{4,   7,  100, 0,  10, 1'b1, 4,  0};
    tbl[4] = '{1,   0,  70,  30, 15, 1'b0, 1,  0};
    tbl[5] = '{64,  63, 80,  20, 80, 1'b0, 64, 63};
    tbl[6] = '{64,  64, 100, 0,  70, 1'b1, 64, 0};
    tbl[7] = '{3,   2,  50,  50, 20, 1'b0, 3,  2};

    // Reset values
    #3;
    chk("rst_pc", DATA_W'(pc), '0);
    chk("rst_conf", DATA_W'(conf_out), '0);
    chk("rst_init", initial_conf, '0);
    chk("rst_flags", DATA_W'({start_unit_exec, load_busy, hdr_err, req_rd_data}), '0);
    @(negedge clk); rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Backpressure on load, then a 3-cycle stall at pc=2
    begin_load(4, 1);
    feed(1000, -1);
    chk("toggle_beats", DATA_W'(beats), DATA_W'(5));
    enter_run(4, 1);
    step(0); step(0);
    step(1); step(1); step(1);
    step(0);
    chk("stall_resume_pc", DATA_W'(pc), DATA_W'(3));
    finish_run();

    // Abort mid-load after two conf words, with a prior header error pending
    begin_load(0, 0);
    feed(1000, 100);
    chk("pre_abort_err", DATA_W'(hdr_err), DATA_W'(1));
    begin_load(4, 0);
    chk("start_clr_err", DATA_W'(hdr_err), '0);
    feed(3, 100);
    abort = 1'b1; available_read = 1'b1; rd_data = words[k];
    #1 chk("abort_req", DATA_W'(req_rd_data), '0);
    @(negedge clk);
    abort = 1'b0;
    #1 chk("abort_idle_req", DATA_W'(req_rd_data), '0);
    chk("abort_busy", DATA_W'(load_busy), '0);
    available_read = 1'b0;
    begin_load(4, 2);
    feed(1000, 100);
    chk("reload_beats", DATA_W'(beats), DATA_W'(5));
    chk("reload_err", DATA_W'(hdr_err), '0);
    enter_run(4, 2);
    for (int i = 0; i < 10; i++) step(0);
    finish_run();

    // Randomized headers against the header model
    for (int r = 0; r < 6; r++) begin
      rv.num = $urandom_range(80); rv.sl = $urandom_range(70);
      rv.avail = 60; rv.stall_pct = 25; rv.run_n = 40;
      model_hdr(rv.num, rv.sl, rv.en, rv.el, rv.err);
      run_vec(rv);
    end

    // Asynchronous reset in the middle of RUN
    begin_load(100, 5);
    feed(1000, 100);
    enter_run(64, 5);
    for (int i = 0; i < 5; i++) step(0);
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", DATA_W'(pc), '0);
    chk("arst_conf", DATA_W'(conf_out), '0);
    chk("arst_init", initial_conf, '0);
    chk("arst_flags", DATA_W'({start_unit_exec, load_busy, hdr_err}), '0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    available_read = 1'b1;
    #1 chk("post_rst_req", DATA_W'(req_rd_data), '0);
    chk("post_rst_run", DATA_W'(start_unit_exec), '0);
    available_read = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
